shift_sequencer: RTL and testbench

//  Multi-step shift controller directly upstream of shifter_module. Accepts a 16-bit operand, op and

---
 rtl/shift_seq_pkg.sv | 32 +++
 rtl/shift_sequencer_if.sv | 26 ++
 rtl/shift_seq_ctrl_decode.sv | 14 +
 rtl/shift_sequencer.sv | 124 ++++++++++++
 tb/tb_shift_sequencer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/shift_seq_pkg.sv
// Shared op encodings, FSM state encoding and the op-to-shifter-control mapping.
package shift_seq_pkg;

  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ASL = 3'b010;
  localparam logic [2:0] OP_ASR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Returns {Rin, Lin, Ain, Bin}; rotates drive neither Ain nor Bin.
  function automatic logic [3:0] op_ctrl(input logic [2:0] op);
    logic [3:0] ctrl;
    case (op)
      OP_LSL:  ctrl = 4'b0101;
      OP_LSR:  ctrl = 4'b1001;
      OP_ASL:  ctrl = 4'b0110;
      OP_ASR:  ctrl = 4'b1010;
      OP_ROL:  ctrl = 4'b0100;
      OP_ROR:  ctrl = 4'b1000;
      default: ctrl = 4'b0000;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between a requester (master) and shift_sequencer (slave).
interface shift_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
);
  logic             start;
  logic [2:0]       op;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] data_in;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             op_err;

  modport master (
    output start, op, count, data_in, carry_in,
    input  busy, done, result, carry_out, op_err
  );

  modport slave (
    input  start, op, count, data_in, carry_in,
    output busy, done, result, carry_out, op_err
  );
endinterface

// File: rtl/shift_seq_ctrl_decode.sv
// Combinational op decode into shifter direction/type controls plus a legal-op flag.
module shift_seq_ctrl_decode
  import shift_seq_pkg::*;
(
  input  logic [2:0] op,
  output logic       rin,
  output logic       lin,
  output logic       ain,
  output logic       bin,
  output logic       legal
);
  assign {rin, lin, ain, bin} = op_ctrl(op);
  assign legal = (op[2:1] != 2'b11);
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: steps an external single-bit shifter count times (SHIFT_SEQ_ABORT_EN adds abort).
// Done N+1 cycles after accept (1 for count 0 / illegal op); start is dropped, not queued, while busy.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SHIFT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  shift_sequencer_if.slave req,
  output logic [WIDTH-1:0] A_bus_o,
  output logic             Rin_o,
  output logic             Lin_o,
  output logic             Ain_o,
  output logic             Bin_o,
  output logic             Cin_o,
  output logic             Din_o,
  output logic             Ein_o,
  output logic             SHS_o,
  input  logic [WIDTH-1:0] sh_result,
  input  logic             sh_cf
);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic             carry;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W:0]   step;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             op_err_q;

  logic d_rin, d_lin, d_ain, d_bin, legal;
  logic abort_hit;
  logic in_shift;

  shift_seq_ctrl_decode u_decode (
    .op    (req.op),
    .rin   (d_rin),
    .lin   (d_lin),
    .ain   (d_ain),
    .bin   (d_bin),
    .legal (legal)
  );

`ifdef SHIFT_SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      work     <= '0;
      carry    <= 1'b0;
      count_q  <= '0;
      step     <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      op_err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req.start) begin
            work    <= req.data_in;
            carry   <= req.carry_in;
            count_q <= req.count;
            step    <= '0;
            ctrl_q  <= {d_rin, d_lin, d_ain, d_bin};
            if (legal && (req.count != '0)) begin
              state <= ST_SHIFT;
            end else begin
              // Nothing to shift: the captured operand is the answer.
              state    <= ST_DONE;
              result_q <= req.data_in;
              carry_q  <= req.carry_in;
              op_err_q <= ~legal;
            end
          end
        end
        ST_SHIFT: begin
          if (abort_hit) begin
            state <= ST_IDLE;
          end else begin
            work  <= sh_result;
            carry <= sh_cf;
            step  <= step + 1'b1;
            if ((step + 1'b1) == {1'b0, count_q}) begin
              state    <= ST_DONE;
              result_q <= sh_result;
              carry_q  <= sh_cf;
              op_err_q <= 1'b0;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_shift = (state == ST_SHIFT);

  assign A_bus_o = in_shift ? work : '0;
  assign {Rin_o, Lin_o, Ain_o, Bin_o} = in_shift ? ctrl_q : 4'b0000;
  assign Cin_o   = in_shift & carry;
  assign Din_o   = 1'b0;
  assign Ein_o   = 1'b0;
  assign SHS_o   = in_shift;

  assign req.busy      = (state != ST_IDLE);
  assign req.done      = (state == ST_DONE);
  assign req.result    = result_q;
  assign req.carry_out = carry_q;
  assign req.op_err    = op_err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer driving a behavioural single-bit shifter; scoreboard checks each done.
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
  logic abort = 1'b0;
`endif

  shift_sequencer_if #(.WIDTH(16), .CNT_W(4)) bus ();

  logic [15:0] A_bus_o, sh_result;
  logic Rin_o, Lin_o, Ain_o, Bin_o, Cin_o, Din_o, Ein_o, SHS_o, sh_cf;

  shift_sequencer #(.WIDTH(16), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SHIFT_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .req       (bus.slave),
    .A_bus_o   (A_bus_o),
    .Rin_o     (Rin_o),
    .Lin_o     (Lin_o),
    .Ain_o     (Ain_o),
    .Bin_o     (Bin_o),
    .Cin_o     (Cin_o),
    .Din_o     (Din_o),
    .Ein_o     (Ein_o),
    .SHS_o     (SHS_o),
    .sh_result (sh_result),
    .sh_cf     (sh_cf)
  );

  always #5 clk = ~clk;

  // Shifter: one bit per step, Cf is the bit shifted out; plain rotate when neither Ain nor Bin.
  always_comb begin
    sh_result = A_bus_o;
    sh_cf     = 1'b0;
    if (Lin_o) begin
      sh_result = {A_bus_o[14:0], (!Ain_o && !Bin_o) ? A_bus_o[15] : 1'b0};
      sh_cf     = A_bus_o[15];
    end else if (Rin_o) begin
      sh_result = {Ain_o ? A_bus_o[15] : ((!Bin_o) ? A_bus_o[0] : 1'b0), A_bus_o[15:1]};
      sh_cf     = A_bus_o[0];
    end
  end

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [3:0]  cnt;
    logic [15:0] data;
    logic        cin;
    logic [15:0] res;
    logic        c;
    logic        err;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic        c;
    logic        err;
    int          cyc;
    int          shs;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  vec_t vecs[12];
  int n_cmp = 0, n_err = 0, cyc = 0, shs_cnt = 0, n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (SHS_o === 1'b1) shs_cnt++;
    if (bus.done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d want done=0", cyc);
      end else begin
        e = sb.pop_front();
        chk($sformatf("%s_result", e.name), 32'(bus.result), 32'(e.res));
        chk($sformatf("%s_carry", e.name), 32'(bus.carry_out), 32'(e.c));
        chk($sformatf("%s_op_err", e.name), 32'(bus.op_err), 32'(e.err));
        chk($sformatf("%s_done_cycle", e.name), cyc, e.cyc);
        chk($sformatf("%s_shs_cycles", e.name), shs_cnt, e.shs);
      end
    end
  end

  task automatic check_all_zero(input string nm);
    chk({nm, "_ctrl"}, 32'({bus.busy, bus.done, bus.carry_out, bus.op_err, SHS_o,
                            Rin_o, Lin_o, Ain_o, Bin_o, Cin_o, Din_o, Ein_o}), 32'd0);
    chk({nm, "_result"}, 32'(bus.result), 32'd0);
    chk({nm, "_abus"}, 32'(A_bus_o), 32'd0);
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [3:0] cnt,
                           input logic [15:0] data, input logic cin);
    bus.op       = op;
    bus.count    = cnt;
    bus.data_in  = data;
    bus.carry_in = cin;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t x;
    int   lat;
    lat      = (v.op[2:1] != 2'b11 && v.cnt != 4'd0) ? int'(v.cnt) + 1 : 1;
    x.name   = v.name;
    x.res    = v.res;
    x.c      = v.c;
    x.err    = v.err;
    x.cyc    = cyc + lat;
    x.shs    = (lat > 1) ? int'(v.cnt) : 0;
    shs_cnt  = 0;
    sb.push_back(x);
    drive_req(v.op, v.cnt, v.data, v.cin);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({v.name, "_busy"}, 32'(bus.busy), 32'd1);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no done want done", v.name);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, d0;
    vecs[0]  = '{"lsl4",  OP_LSL, 4'd4,  16'h1234, 1'b0, 16'h2340, 1'b1, 1'b0};
    vecs[1]  = '{"asr3",  OP_ASR, 4'd3,  16'h8010, 1'b0, 16'hF002, 1'b0, 1'b0};
    vecs[2]  = '{"ror1",  OP_ROR, 4'd1,  16'h0001, 1'b0, 16'h8000, 1'b1, 1'b0};
    vecs[3]  = '{"rol15", OP_ROL, 4'd15, 16'h8001, 1'b0, 16'hC000, 1'b0, 1'b0};
    vecs[4]  = '{"cnt0",  OP_LSL, 4'd0,  16'hBEEF, 1'b1, 16'hBEEF, 1'b1, 1'b0};
    vecs[5]  = '{"ill7",  3'b111, 4'd0,  16'hBEEF, 1'b1, 16'hBEEF, 1'b1, 1'b1};
    vecs[6]  = '{"ill6",  3'b110, 4'd5,  16'h1111, 1'b0, 16'h1111, 1'b0, 1'b1};
    vecs[7]  = '{"lsr2",  OP_LSR, 4'd2,  16'h0003, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{"rol4",  OP_ROL, 4'd4,  16'h1234, 1'b0, 16'h2341, 1'b1, 1'b0};
    vecs[9]  = '{"asl1",  OP_ASL, 4'd1,  16'h4000, 1'b0, 16'h8000, 1'b0, 1'b0};
    vecs[10] = '{"lsr15", OP_LSR, 4'd15, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 1'b0};
    vecs[11] = '{"asr2",  OP_ASR, 4'd2,  16'h7FFE, 1'b1, 16'h1FFF, 1'b1, 1'b0};

    bus.start = 1'b0;
    drive_req(3'b000, 4'd0, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Stray starts mid-operation and in the DONE cycle must be dropped.
    t  = cyc;
    d0 = n_done;
    e.name = "";
    begin
      exp_t x;
      x.name = "ignore"; x.res = 16'hFF00; x.c = 1'b0; x.err = 1'b0;
      x.cyc  = t + 9;    x.shs = 8;
      shs_cnt = 0;
      sb.push_back(x);
    end
    drive_req(OP_LSL, 4'd8, 16'h00FF, 1'b0);
    bus.start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) drive_req(OP_ROR, 4'd3, 16'hAAAA, 1'b1);
      bus.start = (k == 2 || k == 9);
    end
    chk("ignore_sb_empty", 32'(sb.size()), 32'd0);
    chk("ignore_done_count", n_done - d0, 1);
    sb.delete();

    // Reset in the middle of an operation discards it.
    d0 = n_done;
    drive_req(OP_LSR, 4'd6, 16'hF0F0, 1'b0);
    bus.start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 3) rst_n = 1'b0;
      if (k == 4) check_all_zero("midreset");
      if (k == 5) rst_n = 1'b1;
    end
    chk("midreset_done_count", n_done - d0, 0);

`ifdef SHIFT_SEQ_ABORT_EN
    run_vec(vecs[0]);
    d0 = n_done;
    drive_req(OP_LSR, 4'd6, 16'hFFFF, 1'b0);
    bus.start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 2) abort = 1'b1;
      if (k == 3) begin
        abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_result", 32'(bus.result), 32'h2340);
        chk("abort_carry", 32'(bus.carry_out), 32'd1);
      end
    end
    chk("abort_done_count", n_done - d0, 0);
    chk("abort_result_held", 32'(bus.result), 32'h2340);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
